// File: rtl/sprite_pkg.sv
// Shared definitions for the per-line sprite scanner.
// Word layouts, FSM states and the sprite height decode.
package sprite_pkg;

    localparam int SPRITE_COUNT = 128;

    localparam int W0_ADDR_LSB   = 0;
    localparam int W0_MODE_BIT   = 15;
    localparam int W0_X_LSB      = 16;

    localparam int W1_Y_LSB      = 0;
    localparam int W1_HFLIP_BIT  = 16;
    localparam int W1_VFLIP_BIT  = 17;
    localparam int W1_Z_LSB      = 18;
    localparam int W1_COLL_LSB   = 20;
    localparam int W1_PAL_LSB    = 24;
    localparam int W1_WIDTH_LSB  = 28;
    localparam int W1_HEIGHT_LSB = 30;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_Y,
        S_WAIT_Y,
        S_EVAL,
        S_FETCH_A,
        S_WAIT_A,
        S_EMIT,
        S_DONE
    } state_e;

    // Sprite height in pixels: 8, 16, 32 or 64.
    function automatic logic [9:0] h_px(input logic [1:0] height);
        return 10'd8 << height;
    endfunction

endpackage

// File: rtl/sprite_hit_eval.sv
// Decides whether a sprite covers the current line.
// Also yields the sprite row with vertical flip applied.
module sprite_hit_eval
    import sprite_pkg::*;
(
    input  logic [9:0] line,
    input  logic [9:0] y,
    input  logic [1:0] z,
    input  logic [1:0] height,
    input  logic       vflip,
    output logic       hit,
    output logic [5:0] row
);

    logic [9:0] dy;
    logic [9:0] hpx;

    // Distance wraps mod 1024 so sprites near Y=1023 reach line 0.
    always_comb begin
        dy  = line - y;
        hpx = h_px(height);
        hit = (z != 2'd0) && (dy < hpx);
        row = vflip ? 6'(hpx - 10'd1 - dy) : dy[5:0];
    end

endmodule

// File: rtl/sprite_line_scanner.sv
// Walks the sprite attribute RAM once per line start.
// Emits one registered render descriptor per hit sprite.
module sprite_line_scanner
    import sprite_pkg::*;
#(
    parameter int SPRITE_COUNT = sprite_pkg::SPRITE_COUNT,
    parameter int RADDR_WIDTH  = 8,
    parameter int RD_LATENCY   = 1,
    parameter int MAX_HITS     = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   enable_i,
    input  logic                   line_start_i,
    input  logic [9:0]             line_i,
    output logic                   rd_en_o,
    output logic [RADDR_WIDTH-1:0] rd_addr_o,
    input  logic [31:0]            rd_data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [6:0]             out_idx_o,
    output logic [11:0]            out_addr_o,
    output logic                   out_mode_o,
    output logic [9:0]             out_x_o,
    output logic [5:0]             out_row_o,
    output logic                   out_hflip_o,
    output logic [1:0]             out_width_o,
    output logic [3:0]             out_pal_o,
    output logic [1:0]             out_z_o,
    output logic [3:0]             out_coll_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [6:0]             hit_count_o
);

    localparam int IDX_W = RADDR_WIDTH - 1;

    state_e state_q, state_d;

    logic [IDX_W-1:0] idx_q;
    logic [6:0]       hit_count_q;
    logic [1:0]       wait_cnt_q;
    logic [9:0]       line_q;
    logic [9:0]       y_q;
    logic             hflip_q, vflip_q;
    logic [1:0]       z_q, width_q, height_q;
    logic [3:0]       coll_q, pal_q;
    logic [11:0]      addr_q;
    logic             mode_q;
    logic [9:0]       x_q;
    logic [5:0]       row_q;

    logic       hit;
    logic [5:0] row;
    logic       wait_done, last_idx, last_hit;
    logic       unused_rd;

    assign unused_rd = ^rd_data_i[14:12];

    assign wait_done = (wait_cnt_q == 2'(RD_LATENCY - 1));
    assign last_idx  = (idx_q == IDX_W'(SPRITE_COUNT - 1));
    assign last_hit  = (hit_count_q == 7'(MAX_HITS - 1));

    sprite_hit_eval u_hit_eval (
        .line   (line_q),
        .y      (y_q),
        .z      (z_q),
        .height (height_q),
        .vflip  (vflip_q),
        .hit    (hit),
        .row    (row)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next state; a miss or an accept advances straight to the next fetch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    state_d = S_IDLE;
            S_FETCH_Y: state_d = S_WAIT_Y;
            S_WAIT_Y:  if (wait_done) state_d = S_EVAL;
            S_EVAL: begin
                if (hit)           state_d = S_FETCH_A;
                else if (last_idx) state_d = S_DONE;
                else               state_d = S_FETCH_Y;
            end
            S_FETCH_A: state_d = S_WAIT_A;
            S_WAIT_A:  if (wait_done) state_d = S_EMIT;
            S_EMIT: begin
                if (out_ready_i)
                    state_d = (last_idx || last_hit) ? S_DONE : S_FETCH_Y;
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (line_start_i) begin
            if (enable_i)              state_d = S_FETCH_Y;
            else if (state_q == S_IDLE) state_d = S_DONE;
            else                       state_d = S_IDLE;
        end
    end

    // Scan position, hit count and captured sprite words.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            idx_q       <= '0;
            hit_count_q <= '0;
            wait_cnt_q  <= '0;
            line_q      <= '0;
            y_q         <= '0;
            hflip_q     <= 1'b0;
            vflip_q     <= 1'b0;
            z_q         <= '0;
            coll_q      <= '0;
            pal_q       <= '0;
            width_q     <= '0;
            height_q    <= '0;
            addr_q      <= '0;
            mode_q      <= 1'b0;
            x_q         <= '0;
            row_q       <= '0;
        end else if (line_start_i) begin
            line_q      <= line_i;
            idx_q       <= '0;
            hit_count_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            case (state_q)
                S_FETCH_Y, S_FETCH_A: wait_cnt_q <= '0;
                S_WAIT_Y: begin
                    wait_cnt_q <= wait_cnt_q + 2'd1;
                    if (wait_done) begin
                        y_q      <= rd_data_i[W1_Y_LSB +: 10];
                        hflip_q  <= rd_data_i[W1_HFLIP_BIT];
                        vflip_q  <= rd_data_i[W1_VFLIP_BIT];
                        z_q      <= rd_data_i[W1_Z_LSB +: 2];
                        coll_q   <= rd_data_i[W1_COLL_LSB +: 4];
                        pal_q    <= rd_data_i[W1_PAL_LSB +: 4];
                        width_q  <= rd_data_i[W1_WIDTH_LSB +: 2];
                        height_q <= rd_data_i[W1_HEIGHT_LSB +: 2];
                    end
                end
                S_WAIT_A: begin
                    wait_cnt_q <= wait_cnt_q + 2'd1;
                    if (wait_done) begin
                        addr_q <= rd_data_i[W0_ADDR_LSB +: 12];
                        mode_q <= rd_data_i[W0_MODE_BIT];
                        x_q    <= rd_data_i[W0_X_LSB +: 10];
                    end
                end
                S_EVAL: begin
                    row_q <= row;
                    if (!hit && !last_idx) idx_q <= idx_q + IDX_W'(1);
                end
                S_EMIT: begin
                    if (out_ready_i) begin
                        hit_count_q <= hit_count_q + 7'd1;
                        if (!last_idx && !last_hit) idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_en_o   = (state_q == S_FETCH_Y) || (state_q == S_FETCH_A);
    assign rd_addr_o = !rd_en_o ? '0 : {idx_q, state_q == S_FETCH_Y};

    assign out_valid_o = (state_q == S_EMIT);
    assign out_idx_o   = 7'(idx_q);
    assign out_addr_o  = addr_q;
    assign out_mode_o  = mode_q;
    assign out_x_o     = x_q;
    assign out_row_o   = row_q;
    assign out_hflip_o = hflip_q;
    assign out_width_o = width_q;
    assign out_pal_o   = pal_q;
    assign out_z_o     = z_q;
    assign out_coll_o  = coll_q;

    assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o      = (state_q == S_DONE);
    assign hit_count_o = hit_count_q;

endmodule

// File: tb/tb_sprite_line_scanner.sv
// Directed bench for sprite_line_scanner.
// Behavioural sprite RAM with one-cycle read latency.
module tb_sprite_line_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        line_start;
    logic [9:0]  line;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_idx;
    logic [11:0] out_addr;
    logic        out_mode;
    logic [9:0]  out_x;
    logic [5:0]  out_row;
    logic        out_hflip;
    logic [1:0]  out_width;
    logic [3:0]  out_pal;
    logic [1:0]  out_z;
    logic [3:0]  out_coll;
    logic        busy;
    logic        done;
    logic [6:0]  hit_count;

    typedef struct packed {
        logic [6:0]  idx;
        logic [11:0] addr;
        logic        mode;
        logic [9:0]  x;
        logic [5:0]  row;
        logic        hflip;
        logic [1:0]  width;
        logic [3:0]  pal;
        logic [1:0]  z;
        logic [3:0]  coll;
    } desc_t;

    logic [31:0] mem [256];
    desc_t       got[$];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    sprite_line_scanner dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .enable_i     (enable),
        .line_start_i (line_start),
        .line_i       (line),
        .rd_en_o      (rd_en),
        .rd_addr_o    (rd_addr),
        .rd_data_i    (rd_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_idx_o    (out_idx),
        .out_addr_o   (out_addr),
        .out_mode_o   (out_mode),
        .out_x_o      (out_x),
        .out_row_o    (out_row),
        .out_hflip_o  (out_hflip),
        .out_width_o  (out_width),
        .out_pal_o    (out_pal),
        .out_z_o      (out_z),
        .out_coll_o   (out_coll),
        .busy_o       (busy),
        .done_o       (done),
        .hit_count_o  (hit_count)
    );

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic desc_t cur();
        return {out_idx, out_addr, out_mode, out_x, out_row, out_hflip,
                out_width, out_pal, out_z, out_coll};
    endfunction

    function automatic logic [31:0] w1(input logic [9:0] y,
        input logic hf, input logic vf, input logic [1:0] z,
        input logic [3:0] coll, input logic [3:0] pal,
        input logic [1:0] wd, input logic [1:0] ht);
        return {ht, wd, pal, coll, z, vf, hf, 6'd0, y};
    endfunction

    function automatic logic [31:0] w0(input logic [11:0] a,
        input logic m, input logic [9:0] x);
        return {6'd0, x, m, 3'd0, a};
    endfunction

    task automatic start_line(input logic [9:0] ln, input logic en);
        @(negedge clk);
        line       = ln;
        enable     = en;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    // Runs until done; records accepted descriptors, checks stalls.
    task automatic collect(input bit rnd, input int budget,
                           output int ncyc);
        desc_t held = '0;
        bit    stalled = 1'b0;
        bit    seen_done = 1'b0;
        ncyc = 0;
        got.delete();
        while (ncyc < budget) begin
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (stalled) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_fields", 64'(cur()), 64'(held));
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) got.push_back(cur());
            stalled = out_valid && !out_ready;
            held    = cur();
            @(negedge clk);
            ncyc++;
        end
        chk("scan_done_seen", 64'(seen_done), 64'd1);
        out_ready = 1'b1;
    endtask

    int    ncyc;
    desc_t exp_d;

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        line_start = 1'b0;
        line       = '0;
        out_ready  = 1'b1;
        rd_data    = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hitcnt", 64'(hit_count), 64'd0);
        chk("rst_desc", 64'(cur()), 64'd0);
        rst_n = 1'b1;

        // Disabled layer: immediate done, nothing scanned.
        start_line(10'd100, 1'b0);
        chk("dis_done", 64'(done), 64'd1);
        chk("dis_busy", 64'(busy), 64'd0);
        chk("dis_hitcnt", 64'(hit_count), 64'd0);

        // All Z=0: full miss scan takes 128*3 cycles.
        start_line(10'd100, 1'b1);
        chk("miss_busy", 64'(busy), 64'd1);
        collect(1'b0, 2000, ncyc);
        chk("miss_cycles", 64'(ncyc), 64'd384);
        chk("miss_ndesc", 64'(got.size()), 64'd0);
        chk("miss_hitcnt", 64'(hit_count), 64'd0);

        // Sprite 5: Y=96, 16 px, vflip, line 100 -> row 11.
        mem[11] = w1(10'd96, 1'b1, 1'b1, 2'd2, 4'h9, 4'h6, 2'd3, 2'd1);
        mem[10] = w0(12'h5A3, 1'b1, 10'd300);
        start_line(10'd100, 1'b1);
        collect(1'b0, 2000, ncyc);
        exp_d = {7'd5, 12'h5A3, 1'b1, 10'd300, 6'd11, 1'b1, 2'd3,
                 4'h6, 2'd2, 4'h9};
        chk("s5_ndesc", 64'(got.size()), 64'd1);
        if (got.size() > 0) chk("s5_desc", 64'(got[0]), 64'(exp_d));
        chk("s5_hitcnt", 64'(hit_count), 64'd1);
        mem[11] = '0;

        // Sprite 0: Y=1020, 8 px, wraps past line 1023.
        mem[1] = w1(10'd1020, 1'b0, 1'b0, 2'd1, 4'h3, 4'h2, 2'd1, 2'd0);
        mem[0] = w0(12'h00F, 1'b0, 10'd17);
        start_line(10'd1023, 1'b1);
        collect(1'b0, 2000, ncyc);
        chk("wrap1023_n", 64'(got.size()), 64'd1);
        if (got.size() > 0) begin
            chk("wrap1023_row", 64'(got[0].row), 64'd3);
            chk("wrap1023_idx", 64'(got[0].idx), 64'd0);
            chk("wrap1023_x", 64'(got[0].x), 64'd17);
        end
        start_line(10'd3, 1'b1);
        collect(1'b0, 2000, ncyc);
        chk("wrap3_n", 64'(got.size()), 64'd1);
        if (got.size() > 0) chk("wrap3_row", 64'(got[0].row), 64'd7);
        start_line(10'd4, 1'b1);
        collect(1'b0, 2000, ncyc);
        chk("wrap4_n", 64'(got.size()), 64'd0);

        // 128 hits, random backpressure: capped at 64 descriptors.
        for (int i = 0; i < 128; i++) begin
            mem[2*i+1] = w1(10'd200, 1'b0, 1'b0, 2'd3, 4'(i), 4'd0,
                            2'd0, 2'd0);
            mem[2*i]   = w0(12'(i * 3), 1'b0, 10'(i * 2));
        end
        start_line(10'd200, 1'b1);
        collect(1'b1, 5000, ncyc);
        chk("cap_ndesc", 64'(got.size()), 64'd64);
        chk("cap_hitcnt", 64'(hit_count), 64'd64);
        for (int i = 0; i < got.size() && i < 64; i++) begin
            chk($sformatf("cap_idx%0d", i), 64'(got[i].idx), 64'(i));
            chk($sformatf("cap_x%0d", i), 64'(got[i].x), 64'(i * 2));
        end

        // Restart while a descriptor is stalled.
        out_ready = 1'b0;
        start_line(10'd200, 1'b1);
        ncyc = 0;
        while (!out_valid && ncyc < 100) begin
            @(negedge clk);
            ncyc++;
        end
        chk("abort_valid_before", 64'(out_valid), 64'd1);
        line       = 10'd201;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        chk("abort_valid_drop", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd1);
        chk("abort_no_done", 64'(done), 64'd0);
        chk("abort_hitcnt", 64'(hit_count), 64'd0);
        collect(1'b0, 5000, ncyc);
        chk("abort_ndesc", 64'(got.size()), 64'd64);
        if (got.size() > 0) begin
            chk("abort_first_idx", 64'(got[0].idx), 64'd0);
            chk("abort_first_row", 64'(got[0].row), 64'd1);
        end

        // Asynchronous reset in the middle of a scan.
        start_line(10'd200, 1'b1);
        repeat (48) @(negedge clk);
        chk("midrst_busy_pre", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_rd_en", 64'(rd_en), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_hitcnt", 64'(hit_count), 64'd0);
        chk("midrst_desc", 64'(cur()), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_line_scanner.md
# sprite_line_scanner

Per-scanline sprite attribute scanner that sits directly downstream of the sprite attribute RAM read port. On each line-start pulse it walks all 128 sprite entries in index order and finds the sprites that intersect the current line. For each hit it emits one decoded render descriptor over a valid/ready handshake to the sprite line renderer. It stops early once `MAX_HITS` descriptors have been issued.

## Interface

Parameters
- `SPRITE_COUNT`, 128: number of sprite entries; two 32-bit RAM words per sprite.
- `RADDR_WIDTH`, 8: sprite RAM read address width; equals clog2(2*SPRITE_COUNT).
- `RD_LATENCY`, 1: sprite RAM read latency in cycles. 1 = "noreg", 2 = "reg".
- `MAX_HITS`, 64: maximum descriptors emitted per line.

Ports
- `clk_i`  in  1  single clock, shared with the RAM read port.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `enable_i`  in  1  sprite layer enable, sampled at `line_start_i`.
- `line_start_i`  in  1  one-cycle pulse; starts a scan and aborts any scan in progress.
- `line_i`  in  10  current display line, captured on `line_start_i`.
- `rd_en_o`  out  1  RAM read enable.
- `rd_addr_o`  out  RADDR_WIDTH  RAM read address {sprite_idx, word_sel}.
- `rd_data_i`  in  32  RAM read data.
- `out_valid_o`  out  1  descriptor valid.
- `out_ready_i`  in  1  renderer accepts descriptor.
- `out_idx_o`  out  7  sprite index.
- `out_addr_o`  out  12  pattern address[16:5].
- `out_mode_o`  out  1  0 = 4bpp, 1 = 8bpp.
- `out_x_o`  out  10  X position.
- `out_row_o`  out  6  row within the sprite, vflip already applied.
- `out_hflip_o`  out  1  horizontal flip.
- `out_width_o`  out  2  width code.
- `out_pal_o`  out  4  palette offset.
- `out_z_o`  out  2  Z depth.
- `out_coll_o`  out  4  collision mask.
- `busy_o`  out  1  scan in progress.
- `done_o`  out  1  one-cycle pulse at the end of a scan.
- `hit_count_o`  out  7  descriptors emitted on the last or current line.

## Operation

Sprite word layout
- Word 0 (address {idx,0}): [11:0] addr, [15] mode, [25:16] X.
- Word 1 (address {idx,1}): [9:0] Y, [16] hflip, [17] vflip, [19:18] Z, [23:20] coll, [27:24] pal, [29:28] width, [31:30] height.

Hit rule
- dy = (line − Y) mod 1024, computed in 10 bits.
- h_px = 8 << height.
- Hit when Z != 0 and dy < h_px.
- Row = dy[5:0]; if vflip, row = h_px − 1 − dy.

State machine
- IDLE: on `line_start_i` with `enable_i`=1, capture `line_i`, clear idx and hit_count, go to FETCH_Y. With `enable_i`=0, pulse `done_o` with hit_count=0 and stay in IDLE.
- FETCH_Y: `rd_en_o`=1, addr {idx,1} → WAIT_Y.
- WAIT_Y: wait until `rd_data_i` is valid, RD_LATENCY cycles after FETCH_Y; register word 1 → EVAL.
- EVAL: hit → FETCH_A; miss → NEXT.
- FETCH_A: `rd_en_o`=1, addr {idx,0} → WAIT_A.
- WAIT_A: register word 0 → EMIT.
- EMIT: `out_valid_o`=1 and all descriptor fields stable until `out_ready_i`. On accept, hit_count+1 → NEXT.
- NEXT: go to DONE if idx = SPRITE_COUNT−1 or hit_count = MAX_HITS; otherwise idx+1 → FETCH_Y.
- DONE: pulse `done_o` → IDLE.

Boundaries
- `line_start_i` in any non-IDLE state: drop any pending descriptor (`out_valid_o` falls the next cycle), do not pulse `done_o`, restart from idx 0 with the new line.
- `rd_en_o` is low in every state except FETCH_Y and FETCH_A.
- `out_ready_i` while `out_valid_o`=0 is ignored.
- Y near 1023 wraps: Y=1020 with h_px=8 hits lines 1020–1023 and 0–3.

## Timing

- Reset values: all outputs 0; state IDLE.
- Miss cost: RD_LATENCY+2 cycles per sprite (FETCH_Y, WAIT_Y, EVAL, NEXT merged per RD_LATENCY).
- Hit cost: 2·(RD_LATENCY+1)+2 cycles with `out_ready_i` held high, plus any backpressure cycles.
- Full miss scan at RD_LATENCY=1: 128·3 = 384 cycles from `line_start_i` to `done_o`. This must fit within the 800-cycle line budget.
- Descriptor fields are registered; no combinational path from `rd_data_i` to any output.

## Structure

- `sprite_pkg`: word bit-field offsets, state enum, SPRITE_COUNT, h_px decode function.
- One sub-module, `sprite_hit_eval`: combinational; takes line, Y, Z, height, vflip and produces hit and row.

## Test plan

- Reset mid-scan (`rst_n_i` low at cycle 50) → all outputs 0 immediately; `busy_o`=0.
- All Z=0, line 100, RD_LATENCY=1 → no descriptors; `done_o` exactly 384 cycles after `line_start_i`; hit_count 0.
- Sprite 5: Y=96, height=1 (16 px), vflip=1, X=300; line 100 → one descriptor with idx 5, row 11, x 300.
- Sprite 0: Y=1020, height=0; lines 1023, 3, 4 → rows 3, 7, none.
- 128 hits with MAX_HITS=64 and `out_ready_i` random 50% → exactly 64 descriptors, idx 0–63 in order, fields stable while stalled, then `done_o`.
- Second `line_start_i` while EMIT is stalled → old descriptor dropped; the new scan's first descriptor comes from idx 0 with the new line.
